// File: rtl/video_pkg.sv
// Shared definitions for the raster timing generator: the timing record, the
// default 640x480 mode and the coordinate width.
package video_pkg;

    localparam int COORD_W   = 12;
    localparam int MAX_TOTAL = 1 << COORD_W;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } video_timing_t;

    localparam video_timing_t VGA_640x480 = '{
        h_active: 640,
        h_fp:     16,
        h_sync:   96,
        h_bp:     48,
        v_active: 480,
        v_fp:     10,
        v_sync:   2,
        v_bp:     33
    };

    // Raw (undelayed) sync bundle, in the order it travels down the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    function automatic logic in_window(
        input logic [COORD_W-1:0] val,
        input logic [COORD_W-1:0] first,
        input logic [COORD_W-1:0] last
    );
        return (val >= first) && (val <= last);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle between the timing generator, the pixel source and the HDMI PHY.
interface video_timing_gen_if;
    import video_pkg::*;

    logic               enable_i;
    logic [COORD_W-1:0] x_o;
    logic [COORD_W-1:0] y_o;
    logic               fetch_valid_o;
    logic               line_start_o;
    logic               frame_start_o;
    logic               hsync_o;
    logic               vsync_o;
    logic               draw_area_o;

    modport master (
        input  enable_i,
        output x_o, y_o, fetch_valid_o, line_start_o, frame_start_o,
        output hsync_o, vsync_o, draw_area_o
    );

    modport slave (
        output enable_i,
        input  x_o, y_o, fetch_valid_o, line_start_o, frame_start_o,
        input  hsync_o, vsync_o, draw_area_o
    );

endinterface

// File: rtl/video_delay_line.sv
// WIDTH x DEPTH shift register that always shifts; synchronous active-low
// reset loads every stage with RESET_VAL.
module video_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: leading pixel coordinates/strobes for the pixel
// source and PIPE_LAT-delayed hsync/vsync/draw_area for the HDMI PHY.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_640x480.h_active,
    parameter int H_FP       = VGA_640x480.h_fp,
    parameter int H_SYNC     = VGA_640x480.h_sync,
    parameter int H_BP       = VGA_640x480.h_bp,
    parameter int V_ACTIVE   = VGA_640x480.v_active,
    parameter int V_FP       = VGA_640x480.v_fp,
    parameter int V_SYNC     = VGA_640x480.v_sync,
    parameter int V_BP       = VGA_640x480.v_bp,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_LAT   = 2
) (
    input  logic                pixel_clk_i,
    input  logic                rstn_i,
    video_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed %0d", MAX_TOTAL);
        end
        if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_lat_check
            $error("video_timing_gen: PIPE_LAT must be within 1..8");
        end
        if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_width_check
            $error("video_timing_gen: active and sync widths must be at least 1");
        end
    endgenerate

    logic               run_q, run_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;

    // Dropping enable parks the raster at the origin so a restart always
    // begins with a clean frame_start.
    always_comb begin
        run_d = vid.enable_i;
        h_d   = h_q;
        v_d   = v_q;
        if (!vid.enable_i) begin
            h_d = '0;
            v_d = '0;
        end else if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk_i) begin
        if (!rstn_i) begin
            run_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            run_q <= run_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    logic h_active, v_active;
    logic fetch_valid;

    assign h_active    = h_q < H_ACT;
    assign v_active    = v_q < V_ACT;
    assign fetch_valid = run_q & h_active & v_active;

    assign vid.x_o           = h_q;
    assign vid.y_o           = v_q;
    assign vid.fetch_valid_o = fetch_valid;
    assign vid.line_start_o  = run_q & (h_q == '0) & v_active;
    assign vid.frame_start_o = run_q & (h_q == '0) & (v_q == '0);

    sync_bits_t sync_raw, sync_dly;

    assign sync_raw.hs = run_q & in_window(h_q, HS_FIRST, HS_LAST);
    assign sync_raw.vs = run_q & in_window(v_q, VS_FIRST, VS_LAST);
    assign sync_raw.de = fetch_valid;

    // Sync/draw flags lag the coordinates by the pixel source read latency so
    // the PHY sees RGB and its framing on the same cycle.
    video_delay_line #(
        .WIDTH     ($bits(sync_bits_t)),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL ('0)
    ) u_sync_dly (
        .clk_i  (pixel_clk_i),
        .rstn_i (rstn_i),
        .din_i  (sync_raw),
        .dout_o (sync_dly)
    );

    assign vid.hsync_o     = sync_dly.hs ? H_SYNC_POL : ~H_SYNC_POL;
    assign vid.vsync_o     = sync_dly.vs ? V_SYNC_POL : ~V_SYNC_POL;
    assign vid.draw_area_o = sync_dly.de;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a VGA instance and a small high-polarity
// instance, both checked every cycle against a linear pixel-index model.
module tb_video_timing_gen;
    import video_pkg::*;

    typedef struct packed {
        int ha, hf, hw, hb, va, vf, vw, vb, lat;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic fv, ls, fs, hs, vs, de;
    } obs_t;

    typedef struct packed {
        bit       run;
        int       p;
        bit [7:0] hh;
        bit [7:0] vh;
        bit [7:0] dh;
    } mst_t;

    typedef struct {
        bit   rstn;
        bit   en;
        int   n;
        obs_t exp;
    } vec_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
    localparam cfg_t CFG_B = '{16, 2, 4, 3, 8, 2, 2, 3, 3, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rstn_b;
    video_timing_gen_if vid_a ();
    video_timing_gen_if vid_b ();

    video_timing_gen #(
        .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hf), .H_SYNC(CFG_A.hw), .H_BP(CFG_A.hb),
        .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vf), .V_SYNC(CFG_A.vw), .V_BP(CFG_A.vb),
        .H_SYNC_POL(CFG_A.hpol), .V_SYNC_POL(CFG_A.vpol), .PIPE_LAT(CFG_A.lat)
    ) u_dut_a (
        .pixel_clk_i (clk),
        .rstn_i      (rstn_a),
        .vid         (vid_a)
    );

    video_timing_gen #(
        .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hf), .H_SYNC(CFG_B.hw), .H_BP(CFG_B.hb),
        .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vf), .V_SYNC(CFG_B.vw), .V_BP(CFG_B.vb),
        .H_SYNC_POL(CFG_B.hpol), .V_SYNC_POL(CFG_B.vpol), .PIPE_LAT(CFG_B.lat)
    ) u_dut_b (
        .pixel_clk_i (clk),
        .rstn_i      (rstn_b),
        .vid         (vid_b)
    );

    mst_t st_a, st_b;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    function automatic int ht(cfg_t c);
        return c.ha + c.hf + c.hw + c.hb;
    endfunction

    function automatic int vt(cfg_t c);
        return c.va + c.vf + c.vw + c.vb;
    endfunction

    // The model tracks a single pixel index within the frame; coordinates and
    // windows are derived arithmetically, delayed flags come from a history.
    function automatic obs_t model_out(cfg_t c, mst_t s);
        obs_t o;
        int h = s.p % ht(c);
        int v = s.p / ht(c);
        o.x  = 12'(h);
        o.y  = 12'(v);
        o.fv = s.run && h < c.ha && v < c.va;
        o.ls = s.run && h == 0 && v < c.va;
        o.fs = s.run && s.p == 0;
        o.hs = s.hh[c.lat-1] ? c.hpol : !c.hpol;
        o.vs = s.vh[c.lat-1] ? c.vpol : !c.vpol;
        o.de = s.dh[c.lat-1];
        return o;
    endfunction

    function automatic mst_t model_step(cfg_t c, mst_t s, bit rstn, bit en);
        mst_t n;
        int h, v;
        bit hs, vs, de;
        n = '0;
        if (!rstn) return n;
        h  = s.p % ht(c);
        v  = s.p / ht(c);
        hs = s.run && h >= c.ha + c.hf && h < c.ha + c.hf + c.hw;
        vs = s.run && v >= c.va + c.vf && v < c.va + c.vf + c.vw;
        de = s.run && h < c.ha && v < c.va;
        n.hh = {s.hh[6:0], hs};
        n.vh = {s.vh[6:0], vs};
        n.dh = {s.dh[6:0], de};
        if (!en) begin
            n.run = 1'b0;
            n.p   = 0;
        end else begin
            n.run = 1'b1;
            n.p   = s.run ? (s.p + 1) % (ht(c) * vt(c)) : s.p;
        end
        return n;
    endfunction

    function automatic obs_t mk(int x, int y, bit fv, bit ls, bit fs, bit hs, bit vs, bit de);
        obs_t o;
        o.x = 12'(x);
        o.y = 12'(y);
        o.fv = fv; o.ls = ls; o.fs = fs; o.hs = hs; o.vs = vs; o.de = de;
        return o;
    endfunction

    function automatic obs_t get_a();
        return {vid_a.x_o, vid_a.y_o, vid_a.fetch_valid_o, vid_a.line_start_o,
                vid_a.frame_start_o, vid_a.hsync_o, vid_a.vsync_o, vid_a.draw_area_o};
    endfunction

    function automatic obs_t get_b();
        return {vid_b.x_o, vid_b.y_o, vid_b.fetch_valid_o, vid_b.line_start_o,
                vid_b.frame_start_o, vid_b.hsync_o, vid_b.vsync_o, vid_b.draw_area_o};
    endfunction

    task automatic report(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        report("model_a", get_a(), model_out(CFG_A, st_a));
        report("model_b", get_b(), model_out(CFG_B, st_b));
    endtask

    // One pixel clock: drive at the falling edge, step models at the rising
    // edge, compare at the next falling edge.
    task automatic applyStimulus(bit ra, bit ea, bit rb, bit eb);
        rstn_a         = ra;
        vid_a.enable_i = ea;
        rstn_b         = rb;
        vid_b.enable_i = eb;
        @(posedge clk);
        st_a = model_step(CFG_A, st_a, ra, ea);
        st_b = model_step(CFG_B, st_b, rb, eb);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic add_vec(bit r, bit e, int n, obs_t exp);
        vec_t v;
        v.rstn = r;
        v.en   = e;
        v.n    = n;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        int ft_b, t, last_fs, fs_cnt, ls_cnt, first_hs, hs_w, first_vs, vs_w;
        st_a = '0;
        st_b = '0;

        // VGA instance, active-low syncs idle high, PIPE_LAT = 2.
        add_vec(0, 0,   2, mk(  0, 0, 0, 0, 0, 1, 1, 0));
        add_vec(1, 0,   3, mk(  0, 0, 0, 0, 0, 1, 1, 0));
        add_vec(1, 1,   1, mk(  0, 0, 1, 1, 1, 1, 1, 0));
        add_vec(1, 1,   2, mk(  2, 0, 1, 0, 0, 1, 1, 1));
        add_vec(1, 1, 637, mk(639, 0, 1, 0, 0, 1, 1, 1));
        add_vec(1, 1,   1, mk(640, 0, 0, 0, 0, 1, 1, 1));
        add_vec(1, 1,   2, mk(642, 0, 0, 0, 0, 1, 1, 0));
        add_vec(1, 1,  15, mk(657, 0, 0, 0, 0, 1, 1, 0));
        add_vec(1, 1,   1, mk(658, 0, 0, 0, 0, 0, 1, 0));
        add_vec(1, 1,  95, mk(753, 0, 0, 0, 0, 0, 1, 0));
        add_vec(1, 1,   1, mk(754, 0, 0, 0, 0, 1, 1, 0));
        add_vec(1, 1,  46, mk(  0, 1, 1, 1, 0, 1, 1, 0));
        add_vec(1, 1,   2, mk(  2, 1, 1, 0, 0, 1, 1, 1));
        add_vec(1, 1, 698, mk(700, 1, 0, 0, 0, 0, 1, 0));
        add_vec(0, 1,   1, mk(  0, 0, 0, 0, 0, 1, 1, 0));
        add_vec(1, 1,   1, mk(  0, 0, 1, 1, 1, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].n) applyStimulus(vecs[i].rstn, vecs[i].en, 1'b0, 1'b0);
            report($sformatf("vec%0d", i), get_a(), vecs[i].exp);
        end

        check_val("b_idle_sync", {30'd0, vid_b.hsync_o, vid_b.vsync_o}, 32'd0);

        // Small instance: enable drop mid-frame, then restart.
        applyStimulus(1, 1, 1, 1);
        check_val("b_first_frame_start", 32'(vid_b.frame_start_o), 32'd1);
        repeat (135) applyStimulus(1, 1, 1, 1);
        check_val("b_pre_drop_xy", {8'd0, vid_b.x_o, vid_b.y_o}, {8'd0, 12'd10, 12'd5});
        applyStimulus(1, 1, 1, 0);
        check_val("b_drop_xyfv", {7'd0, vid_b.x_o, vid_b.y_o, vid_b.fetch_valid_o}, 32'd0);
        check_val("b_drop_de_early", 32'(vid_b.draw_area_o), 32'd1);
        repeat (2) applyStimulus(1, 1, 1, 0);
        check_val("b_drop_de_hold", 32'(vid_b.draw_area_o), 32'd1);
        applyStimulus(1, 1, 1, 0);
        check_val("b_drop_de_fall", 32'(vid_b.draw_area_o), 32'd0);
        applyStimulus(1, 1, 1, 1);
        check_val("b_restart", 32'(vid_b.frame_start_o), 32'd1);

        // Two full frames of the small instance, measured against the timing rules.
        ft_b     = ht(CFG_B) * vt(CFG_B);
        last_fs  = 0;
        fs_cnt   = 1;
        ls_cnt   = 1;
        first_hs = -1;
        hs_w     = 0;
        first_vs = -1;
        vs_w     = 0;
        for (t = 1; t <= 2 * ft_b; t++) begin
            applyStimulus(1, 1, 1, 1);
            if (vid_b.frame_start_o === 1'b1) begin
                check_val("b_frame_period", 32'(t - last_fs), 32'(ft_b));
                last_fs = t;
                fs_cnt++;
            end
            if (t < ft_b) begin
                if (vid_b.line_start_o === 1'b1) ls_cnt++;
                if (vid_b.hsync_o === 1'b1 && first_hs < 0) first_hs = t;
                if (vid_b.hsync_o === 1'b1 && t < ht(CFG_B)) hs_w++;
                if (vid_b.vsync_o === 1'b1) begin
                    if (first_vs < 0) first_vs = t;
                    vs_w++;
                end
            end
        end
        check_val("b_frame_count", 32'(fs_cnt), 32'd3);
        check_val("b_line_starts", 32'(ls_cnt), 32'(CFG_B.va));
        check_val("b_hsync_offset", 32'(first_hs), 32'(CFG_B.ha + CFG_B.hf + CFG_B.lat));
        check_val("b_hsync_width", 32'(hs_w), 32'(CFG_B.hw));
        check_val("b_vsync_offset", 32'(first_vs),
                  32'((CFG_B.va + CFG_B.vf) * ht(CFG_B) + CFG_B.lat));
        check_val("b_vsync_width", 32'(vs_w), 32'(CFG_B.vw * ht(CFG_B)));

        // Randomised enable drops and resets on both instances.
        repeat (3000) begin
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 97,
                          $urandom_range(0, 199) != 0, $urandom_range(0, 99) < 97);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
